// File: rtl/des_sbox_seq_pkg.sv
// Shared definitions for the iterative DES S-box stage: sizes, FSM state
// encoding, the eight FIPS 46-3 substitution tables and small helpers.
// Optional build macro used elsewhere in the slice: DES_SBOX_PARITY_EN.
package des_pkg;

  localparam int DES_SBOX_NUM   = 8;
  localparam int DES_SBOX_IN_W  = 6;
  localparam int DES_SBOX_OUT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_state_e;

  // One 256-bit word per box; entry 0 (row 0, col 0) is the most significant
  // hex digit, so entry k lives at bits [4*(63-k) +: 4].
  localparam logic [DES_SBOX_NUM-1:0][255:0] DES_SBOX_TBL = {
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B, // S8
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C, // S7
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D, // S6
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453, // S5
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E, // S4
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C, // S3
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9, // S2
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D  // S1
  };

  // Table read: idx is row*16+col; ~idx*4 turns the MSB-first layout into a bit offset.
  function automatic logic [DES_SBOX_OUT_W-1:0] des_sbox_lookup(
    input logic [2:0] box,
    input logic [5:0] idx
  );
    logic [255:0] box_bits;
    box_bits = DES_SBOX_TBL[box];
    return box_bits[{~idx, 2'b00} +: 4];
  endfunction

  // Odd parity over the substituted word (inverted XOR reduction).
  function automatic logic des_odd_par(input logic [31:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/des_sbox_seq_if.sv
// Handshake bundle between the expansion/key-mix stage, the S-box stage and
// the downstream P-box. out_par exists only with DES_SBOX_PARITY_EN defined.
interface des_sbox_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef DES_SBOX_PARITY_EN
  logic        out_par;
`endif

  // Environment side: drives words in, consumes results.
  modport master (
`ifdef DES_SBOX_PARITY_EN
    input  out_par,
`endif
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // S-box stage side.
  modport slave (
`ifdef DES_SBOX_PARITY_EN
    output out_par,
`endif
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/des_sbox_seq_lut.sv
// Single DES S-box lookup. six_in is in DES order: six_in[5] is the first
// (row MSB) bit, six_in[0] the last (row LSB), six_in[4:1] the column.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]                box_idx,
  input  logic [DES_SBOX_IN_W-1:0]  six_in,
  output logic [DES_SBOX_OUT_W-1:0] four_out
);

  logic [5:0] tbl_idx_s;

  // Form row*16+col from the outer and inner bits, then read the table.
  always_comb begin
    tbl_idx_s = {six_in[5], six_in[0], six_in[4:1]};
    four_out  = des_sbox_lookup(box_idx, tbl_idx_s);
  end

endmodule

// File: rtl/des_sbox_seq.sv
// Iterative S-box substitution for the DES f-function. SBOX_PER_CYCLE boxes
// are evaluated per RUN cycle; the finished word is held in DONE until the
// P-box stage accepts it. Optional macro DES_SBOX_PARITY_EN adds out_par.
module des_sbox_seq
  import des_pkg::*;
#(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  des_sbox_seq_if.slave  bus,
  output logic           busy
);

  localparam int ITER = DES_SBOX_NUM / SBOX_PER_CYCLE;

  if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
        SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
    $error("des_sbox_seq: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  des_state_e  state_q;
  logic [2:0]  cnt_q;
  logic [47:0] word_q;
  logic [31:0] out_data_q;
  logic [31:0] out_data_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
`ifdef DES_SBOX_PARITY_EN
  logic        out_par_q;
`endif

  logic [SBOX_PER_CYCLE-1:0][2:0] box_s;
  logic [SBOX_PER_CYCLE-1:0][5:0] grp_s;
  logic [SBOX_PER_CYCLE-1:0][5:0] six_s;
  logic [SBOX_PER_CYCLE-1:0][3:0] nib_s;

  // Lane g handles box cnt*SBOX_PER_CYCLE+g; word bit 6j is DES bit 1 of box j,
  // so the 6-bit group is bit-reversed into DES order for the lookup.
  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_lane
    assign box_s[g] = 3'((int'(cnt_q) * SBOX_PER_CYCLE) + g);
    assign grp_s[g] = word_q[6*box_s[g] +: 6];
    assign six_s[g] = {grp_s[g][0], grp_s[g][1], grp_s[g][2],
                       grp_s[g][3], grp_s[g][4], grp_s[g][5]};

    des_sbox_lut u_lut (
      .box_idx  (box_s[g]),
      .six_in   (six_s[g]),
      .four_out (nib_s[g])
    );
  end

  // Merge this cycle's nibbles into the output word; result MSB lands on out_data[4j].
  always_comb begin
    out_data_d = out_data_q;
    for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
      out_data_d[4*box_s[k] +: 4] = {nib_s[k][0], nib_s[k][1], nib_s[k][2], nib_s[k][3]};
    end
  end

  // Control FSM with registered handshake outputs; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      word_q      <= 48'd0;
      out_data_q  <= 32'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DES_SBOX_PARITY_EN
      out_par_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_q     <= bus.in_data;
            cnt_q      <= 3'd0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          out_data_q <= out_data_d;
`ifdef DES_SBOX_PARITY_EN
          out_par_q  <= des_odd_par(out_data_d);
`endif
          if (cnt_q == 3'(ITER - 1)) begin
            cnt_q       <= 3'd0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          // Word offered on the same edge is not taken; IDLE accepts it next edge.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= 3'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
`ifdef DES_SBOX_PARITY_EN
  assign bus.out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed bench for des_sbox_seq. The main instance uses SBOX_PER_CYCLE=1;
// three more instances (2, 4, 8) share the same stimulus for width checks.
module tb_des_sbox_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_r;
  logic        out_ready_r;
  logic [47:0] in_data_r;
  logic        busy1, busy2, busy4, busy8;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  des_sbox_seq_if b1 ();
  des_sbox_seq_if b2 ();
  des_sbox_seq_if b4 ();
  des_sbox_seq_if b8 ();

  assign b1.in_valid = in_valid_r;  assign b1.in_data = in_data_r;  assign b1.out_ready = out_ready_r;
  assign b2.in_valid = in_valid_r;  assign b2.in_data = in_data_r;  assign b2.out_ready = out_ready_r;
  assign b4.in_valid = in_valid_r;  assign b4.in_data = in_data_r;  assign b4.out_ready = out_ready_r;
  assign b8.in_valid = in_valid_r;  assign b8.in_data = in_data_r;  assign b8.out_ready = out_ready_r;

  des_sbox_seq #(.SBOX_PER_CYCLE(1)) dut    (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(busy1));
  des_sbox_seq #(.SBOX_PER_CYCLE(2)) u_spc2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave), .busy(busy2));
  des_sbox_seq #(.SBOX_PER_CYCLE(4)) u_spc4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy(busy4));
  des_sbox_seq #(.SBOX_PER_CYCLE(8)) u_spc8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave), .busy(busy8));

  // Reference tables, one 16-digit row per entry, index box*4+row, col 0 leftmost.
  localparam logic [63:0] REF_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Nibble string (S1 leftmost, MSB first) to out_data layout (out_data[4j] = MSB).
  function automatic logic [31:0] nib_to_word(input logic [31:0] nibs);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 8; j++)
      for (int b = 0; b < 4; b++)
        w[4*j+b] = nibs[31-4*j-b];
    return w;
  endfunction

  function automatic logic [31:0] ref_sbox(input logic [47:0] d);
    logic [31:0] nibs;
    logic [63:0] rowv;
    int r, c;
    nibs = 32'd0;
    for (int j = 0; j < 8; j++) begin
      r = 2 * int'(d[6*j]) + int'(d[6*j+5]);
      c = 8 * int'(d[6*j+1]) + 4 * int'(d[6*j+2]) + 2 * int'(d[6*j+3]) + int'(d[6*j+4]);
      rowv = REF_ROWS[4*j+r];
      nibs[31-4*j -: 4] = rowv[63-4*c -: 4];
    end
    return nib_to_word(nibs);
  endfunction

  // Offer one word at a falling edge; it is accepted on the next rising edge.
  task automatic send_word(input logic [47:0] d);
    in_valid_r = 1'b1;
    in_data_r  = d;
    @(negedge clk);
    in_valid_r = 1'b0;
    in_data_r  = 48'hA5A5_5A5A_C3C3;
  endtask

  // Count edges after the accept edge until the main instance raises out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (b1.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain;
    in_valid_r  = 1'b0;
    out_ready_r = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid_r = 1'b0; in_data_r = 48'd0; out_ready_r = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", b1.out_valid); end
    checks++; if (b1.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got=%h want=0", b1.out_data); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy1); end
`ifdef DES_SBOX_PARITY_EN
    checks++; if (b1.out_par !== 1'b1) begin errors++; $display("FAIL reset_out_par got=%b want=1", b1.out_par); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", b1.in_ready); end
  endtask

  task automatic test_zero;
    int lat;
    logic [31:0] exp_w;
    exp_w = nib_to_word(32'hEFA72C4D);
    out_ready_r = 1'b1;
    send_word(48'd0);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got=%0d want=8", lat); end
    checks++; if (b1.out_data !== exp_w) begin errors++; $display("FAIL zero_data got=%h want=%h", b1.out_data, exp_w); end
`ifdef DES_SBOX_PARITY_EN
    checks++; if (b1.out_par !== ~^exp_w) begin errors++; $display("FAIL zero_par got=%b want=%b", b1.out_par, ~^exp_w); end
`endif
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_handshake valid=%b ready=%b want 0/1", b1.out_valid, b1.in_ready); end
  endtask

  task automatic test_directed;
    logic [47:0] vin  [2] = '{48'hFFFFFF000000, 48'hDB6DB6DB6DB6};
    logic [31:0] vnib [2] = '{32'hEFA73DCB, 32'h59BA9BFE};
    int lat;
    for (int v = 0; v < 2; v++) begin
      drain();
      send_word(vin[v]);
      wait_valid(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL dir%0d_latency got=%0d want=8", v, lat); end
      checks++; if (b1.out_data !== nib_to_word(vnib[v])) begin
        errors++; $display("FAIL dir%0d_data got=%h want=%h", v, b1.out_data, nib_to_word(vnib[v])); end
    end
  endtask

  task automatic test_widths;
    int lat_a [4];
    logic [31:0] dat_a [4];
    logic [31:0] exp_w;
    exp_w = nib_to_word(32'hD9CE3DCB);
    for (int i = 0; i < 4; i++) begin lat_a[i] = -1; dat_a[i] = 32'd0; end
    drain();
    send_word(48'hFFFF_FFFF_FFFF);
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) @(negedge clk);
      if (lat_a[0] < 0 && b1.out_valid === 1'b1) begin lat_a[0] = n; dat_a[0] = b1.out_data; end
      if (lat_a[1] < 0 && b2.out_valid === 1'b1) begin lat_a[1] = n; dat_a[1] = b2.out_data; end
      if (lat_a[2] < 0 && b4.out_valid === 1'b1) begin lat_a[2] = n; dat_a[2] = b4.out_data; end
      if (lat_a[3] < 0 && b8.out_valid === 1'b1) begin lat_a[3] = n; dat_a[3] = b8.out_data; end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (lat_a[i] !== (8 >> i)) begin
        errors++; $display("FAIL ones_latency_spc%0d got=%0d want=%0d", 1 << i, lat_a[i], 8 >> i); end
      checks++; if (dat_a[i] !== exp_w) begin
        errors++; $display("FAIL ones_data_spc%0d got=%h want=%h", 1 << i, dat_a[i], exp_w); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [31:0] exp_w;
    exp_w = nib_to_word(32'h59BA9BFE);
    drain();
    out_ready_r = 1'b0;
    send_word(48'hDB6DB6DB6DB6);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got=%0d want=8", lat); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b want=1", c, b1.out_valid); end
      checks++; if (b1.out_data !== exp_w) begin errors++; $display("FAIL bp_data cyc=%0d got=%h want=%h", c, b1.out_data, exp_w); end
      checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, b1.in_ready); end
    end
    out_ready_r = 1'b1;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b want 0/1", b1.out_valid, b1.in_ready); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    drain();
    send_word(48'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", b1.out_valid); end
    checks++; if (b1.out_data !== 32'd0) begin errors++; $display("FAIL midrst_data got=%h want=0", b1.out_data); end
    checks++; if (busy1 !== 1'b0 || b1.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state busy=%b ready=%b want 0/1", busy1, b1.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy1 !== 1'b0 || b1.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_discard busy=%b valid=%b want 0/0", busy1, b1.out_valid); end
    send_word(48'hDB6DB6DB6DB6);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_latency got=%0d want=8", lat); end
    checks++; if (b1.out_data !== nib_to_word(32'h59BA9BFE)) begin
      errors++; $display("FAIL midrst_data2 got=%h want=%h", b1.out_data, nib_to_word(32'h59BA9BFE)); end
  endtask

  task automatic test_handover;
    int lat;
    drain();
    out_ready_r = 1'b0;
    send_word(48'hFFFFFF000000);
    wait_valid(lat);
    in_valid_r  = 1'b1;
    in_data_r   = 48'hDB6DB6DB6DB6;
    out_ready_r = 1'b1;
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL ho_no_accept valid=%b ready=%b busy=%b want 0/1/0", b1.out_valid, b1.in_ready, busy1); end
    @(negedge clk);
    in_valid_r = 1'b0;
    checks++; if (busy1 !== 1'b1 || b1.in_ready !== 1'b0) begin
      errors++; $display("FAIL ho_accept busy=%b ready=%b want 1/0", busy1, b1.in_ready); end
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ho_latency got=%0d want=8", lat); end
    checks++; if (b1.out_data !== nib_to_word(32'h59BA9BFE)) begin
      errors++; $display("FAIL ho_data got=%h want=%h", b1.out_data, nib_to_word(32'h59BA9BFE)); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    int sent, recv, cyc;
    bit acc_prev;
    sent = 0; recv = 0; cyc = 0; acc_prev = 1'b0;
    drain();
    in_data_r = {16'($urandom), $urandom};
    while (recv < 12 && cyc < 3000) begin
      if (acc_prev) in_data_r = {16'($urandom), $urandom};
      in_valid_r  = (sent < 12);
      out_ready_r = 1'($urandom_range(0, 1));
      acc_prev    = in_valid_r && (b1.in_ready === 1'b1);
      if (acc_prev) begin
        exp_q.push_back(ref_sbox(in_data_r));
        sent++;
      end
      if (b1.out_valid === 1'b1 && out_ready_r) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got=%h want=none", b1.out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (b1.out_data !== exp_w) begin
            errors++; $display("FAIL b2b_data idx=%0d got=%h want=%h", recv, b1.out_data, exp_w); end
        end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_r = 1'b0;
    checks++; if (recv !== 12) begin errors++; $display("FAIL b2b_count got=%0d want=12", recv); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_widths();
    test_backpressure();
    test_reset_mid_run();
    test_handover();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_sbox_seq.md
Name: des_sbox_seq

Overview:
Iterative S-box substitution stage of the DES f-function. It accepts the 48-bit (expansion XOR subkey) word and evaluates S1..S8 over several cycles, SBOX_PER_CYCLE boxes per cycle. It presents the 32-bit substituted word to the straight P-box directly downstream, using valid/ready handshakes on both sides.

Parameters:
SBOX_PER_CYCLE, 1, S-boxes evaluated per RUN cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
ITER, 8/SBOX_PER_CYCLE (localparam), number of RUN cycles per block.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
in_valid  in  1  upstream word valid.
in_ready  out  1  stage can accept a word.
in_data  in  48  expansion XOR subkey; in_data[i] holds DES bit i+1.
out_valid  out  1  out_data valid.
out_ready  in  1  P-box stage accepts.
out_data  out  32  substituted word; out_data[i] holds DES bit i+1.
busy  out  1  high in RUN or DONE.

Behaviour:
- Bit mapping: S-box j (0..7) takes the 6 bits in_data[6j..6j+5].
  - Row is {in_data[6j], in_data[6j+5]}.
  - Column is in_data[6j+1..6j+4], with in_data[6j+1] as the column MSB.
  - The 4-bit result goes to out_data[4j..4j+3], with out_data[4j] = result MSB.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, latch in_data into an internal register, set cnt=0 and go to RUN.
  - RUN: each cycle evaluate boxes cnt*SBOX_PER_CYCLE .. +SBOX_PER_CYCLE-1 from the latched word and write their nibbles into the out_data register. Then cnt++. When cnt==ITER-1, go to DONE.
  - DONE: out_valid=1, out_data stable. When out_ready=1, go to IDLE.
- in_ready=1 only in IDLE. Changes on in_data outside the accept edge have no effect.
- Latency: out_valid rises ITER clock edges after the accept edge; that is 8 edges at SBOX_PER_CYCLE=1.
- Throughput: one word every ITER+2 cycles when out_ready is held high.
- Backpressure: DONE holds indefinitely while out_ready=0, with out_data unchanged.
- Unfinished nibbles in out_data are don't-care until DONE. out_data is only meaningful while out_valid=1.
- Reset (async assert, any state, including mid-RUN):
  - state=IDLE, cnt=0.
  - out_data=0, out_valid=0, in_ready=1 after reset release, busy=0.
  - The in-flight word is discarded; no partial output is ever flagged valid.
- in_valid together with the DONE-to-IDLE handshake edge: the word is not accepted that cycle. It is accepted in IDLE on the next edge.
- out_ready while not in DONE: ignored.

Optional Feature:
Macro DES_SBOX_PARITY_EN.
- Defined: adds output port out_par (1 bit), registered, equal to odd parity of out_data (XOR of all 32 bits, inverted). It is valid with out_valid and resets to 1.
- Undefined: out_par port absent; no parity logic.

Decomposition:
- Package des_pkg holds:
  - DES_SBOX_NUM=8, DES_SBOX_IN_W=6, DES_SBOX_OUT_W=4;
  - the S-box table constant (8 x 64 x 4 bits, standard FIPS 46-3 values, indexed [box][row*16+col]);
  - the FSM state enum {IDLE, RUN, DONE}.
- One combinational sub-module, des_sbox_lut, with inputs box_idx[2:0] and six_in[5:0] and output four_out[3:0]. It is instantiated SBOX_PER_CYCLE times, with box_idx driven from cnt.

Test Plan:
- in_data=48'h0, out_ready=1 -> out_data nibbles (read out_data[0..31] MSB-first per nibble) E F A 7 2 C 4 D; out_valid rises 8 edges after accept.
- in_data all ones -> nibbles D 9 C E 3 D C B; repeat with SBOX_PER_CYCLE=2, 4 and 8 -> identical data, latency 4, 2 and 1 edges.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, out_data stable, in_ready=0 throughout; release -> IDLE next edge.
- rst_n pulsed low at RUN cycle 3 -> out_valid=0 and out_data=0 immediately; the next word completes normally with correct value.
- Back-to-back random 48-bit words, in_valid held high, out_ready toggling randomly -> every output matches the reference model, in order, with no drop or duplicate.
- DES_SBOX_PARITY_EN defined, all-zero input -> out_par = ~^(32'hEFA72C4D bit pattern); reset value of out_par = 1.
